shift_left_iterative: RTL and testbench
=======================================

SHIFT_LEFT_ITERATIVE -- requirements
Module: shift_left_iterative

Interface
REQ-001: clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-002: reset  input  1  asynchronous, active-high; SHALL force all state and outputs to reset values immediately, independent of clock.
REQ-003: ctrl_start  input  1  request strobe; SHALL be sampled on each rising edge of clock.
REQ-004: data_operandA  input  32  operand to shift; SHALL be captured only on the edge where a start is accepted.
REQ-005: ctrl_shiftamt  input  5  left-shift amount, 0..31, unsigned; SHALL be captured together with data_operandA.
REQ-006: data_result  output  32  registered shift result.
REQ-007: data_resultRDY  output  1  one-cycle pulse marking data_result valid.
REQ-008: ctrl_busy  output  1  high while a shift is in progress.

Function
REQ-009: Operation SHALL be logical left shift: result = operandA << shiftamt; bits shifted out of bit 31 SHALL be discarded; vacated low bits SHALL be zero-filled.
REQ-010: FSM SHALL have exactly three states: IDLE, SHIFT, DONE; reset state IDLE.
REQ-011: IDLE: if ctrl_start=1 at edge E0, block SHALL latch data_operandA into a 32-bit working register, latch ctrl_shiftamt, load stage index 4, and go to SHIFT; otherwise remain IDLE.
REQ-012: SHIFT: one stage per edge, stage index k from 4 down to 0 (weights 16, 8, 4, 2, 1); if latched shiftamt[k]=1, working register SHALL shift left by 2^k, else hold.
REQ-013: Stage index SHALL decrement each SHIFT edge; after the k=0 edge (E5) FSM SHALL go to DONE; stage index SHALL NOT wrap below 0.
REQ-014: On E5, data_result SHALL load the final working value; data_resultRDY SHALL be high for exactly the cycle following E5 (DONE state).
REQ-015: Latency SHALL be fixed: start accepted at E0, data_resultRDY high between E5 and E6, for every shiftamt including 0.
REQ-016: ctrl_busy SHALL be high between E0 and E5 (SHIFT state), low in IDLE and DONE.
REQ-017: ctrl_start while in SHIFT SHALL be ignored; latched operand and amount SHALL NOT change.
REQ-018: ctrl_start=1 sampled in DONE SHALL be accepted as a new E0 (back-to-back), going directly to SHIFT; otherwise DONE SHALL go to IDLE.
REQ-019: data_result SHALL hold its last value until the next E5 load or reset; it SHALL NOT change during SHIFT.
REQ-020: Input changes on data_operandA/ctrl_shiftamt after E0 SHALL NOT affect the in-progress result.

Reset
REQ-021: While reset=1: state IDLE, data_result=32'h00000000, data_resultRDY=0, ctrl_busy=0, working register, latched amount, stage index all 0.
REQ-022: Reset asserted mid-operation SHALL abort the shift; no data_resultRDY pulse for the aborted request.
REQ-023: After reset deasserts, the first rising edge with ctrl_start=1 SHALL be accepted as E0.

Verification
REQ-024: operandA=32'h00000001, shiftamt=31, start -> ctrl_busy high 5 cycles, data_result=32'h80000000, data_resultRDY one-cycle pulse after E5.
REQ-025: operandA=32'hDEADBEEF, shiftamt=0 -> data_result=32'hDEADBEEF after full 5-cycle latency; shiftamt=4 -> 32'hEADBEEF0; shiftamt=16 -> 32'hBEEF0000.
REQ-026: start with operandA=32'h0000FFFF, shiftamt=8, then drive operandA=0 and pulse ctrl_start during SHIFT -> data_result=32'h00FFFF00, single RDY pulse.
REQ-027: back-to-back: second start (operandA=32'h00000003, shiftamt=1) held high in DONE cycle -> second RDY 6 cycles after first, data_result=32'h00000006.
REQ-028: assert reset at E3 of a shift -> outputs immediately zero, no RDY pulse; new start after release completes normally.
REQ-029: randomized operandA/shiftamt sweep (all 32 amounts) -> every data_result equals reference operandA << shiftamt, latency always 5 edges.

Source files
------------

// File: rtl/shift_left_iterative.sv
// Iterative 32-bit logical left shifter.
// A start latches the operand and amount, then five SHIFT cycles apply the
// power-of-two stages 16, 8, 4, 2, 1 in that order. The latency is fixed for
// every amount, including zero.
// The result is registered and held until the next completion or reset.
module shift_left_iterative (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_start,
    input  logic [31:0] data_operandA,
    input  logic [4:0]  ctrl_shiftamt,
    output logic [31:0] data_result,
    output logic        data_resultRDY,
    output logic        ctrl_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] work_q;
    logic [31:0] work_d;
    logic [31:0] result_q;
    logic [4:0]  amt_q;
    logic [2:0]  stage_q;
    logic        rdy_q;
    logic        busy_q;

    // Working value after applying the current stage (shift by 2^stage if that amount bit is set)
    always_comb begin
        work_d = work_q;
        case (stage_q)
            3'd4:    if (amt_q[4]) work_d = {work_q[15:0], 16'h0000};
            3'd3:    if (amt_q[3]) work_d = {work_q[23:0], 8'h00};
            3'd2:    if (amt_q[2]) work_d = {work_q[27:0], 4'h0};
            3'd1:    if (amt_q[1]) work_d = {work_q[29:0], 2'b00};
            3'd0:    if (amt_q[0]) work_d = {work_q[30:0], 1'b0};
            default: work_d = work_q;
        endcase
    end

    // Control FSM with registered busy/ready outputs and the datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            work_q   <= 32'h0000_0000;
            result_q <= 32'h0000_0000;
            amt_q    <= 5'd0;
            stage_q  <= 3'd0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ctrl_start) begin
                        work_q  <= data_operandA;
                        amt_q   <= ctrl_shiftamt;
                        stage_q <= 3'd4;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Start requests are ignored here; latched operands stay put
                    work_q <= work_d;
                    if (stage_q == 3'd0) begin
                        // Last stage: publish the result; stage index stays at 0
                        result_q <= work_d;
                        rdy_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= DONE;
                    end else begin
                        stage_q <= stage_q - 3'd1;
                    end
                end
                DONE: begin
                    // A start seen in the ready cycle begins the next shift immediately
                    if (ctrl_start) begin
                        work_q  <= data_operandA;
                        amt_q   <= ctrl_shiftamt;
                        stage_q <= 3'd4;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_resultRDY = rdy_q;
    assign ctrl_busy      = busy_q;

endmodule

// File: tb/tb_shift_left_iterative.sv
// Directed bench for shift_left_iterative: reset state, fixed five-cycle
// latency, start ignored while busy, back-to-back start, mid-run reset
// and a sweep over all 32 shift amounts.
module tb_shift_left_iterative;

    logic        clock;
    logic        reset;
    logic        ctrl_start;
    logic [31:0] data_operandA;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        ctrl_busy;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] prev_result;

    shift_left_iterative dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .data_operandA  (data_operandA),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .ctrl_busy      (ctrl_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issues a start, then checks every cycle through E5.
    // With glitch set, start is pulsed and the inputs are changed during SHIFT.
    // Returns after the E5 check so the caller controls the DONE cycle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] amt,
                          input logic [31:0] exp, input bit glitch);
        @(negedge clock);
        ctrl_start    = 1'b1;
        data_operandA = a;
        ctrl_shiftamt = amt;
        @(posedge clock); #1;
        chk({tag, " E0 busy"}, {31'd0, ctrl_busy}, 32'd1);
        @(negedge clock);
        ctrl_start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock); #1;
            chk({tag, " shift busy"}, {31'd0, ctrl_busy}, 32'd1);
            chk({tag, " shift rdy"}, {31'd0, data_resultRDY}, 32'd0);
            chk({tag, " shift hold"}, data_result, prev_result);
            if (glitch) begin
                @(negedge clock);
                ctrl_start    = (k == 1);
                data_operandA = 32'h0000_0000;
                ctrl_shiftamt = 5'd0;
            end
        end
        @(posedge clock); #1;
        chk({tag, " E5 result"}, data_result, exp);
        chk({tag, " E5 rdy"}, {31'd0, data_resultRDY}, 32'd1);
        chk({tag, " E5 busy"}, {31'd0, ctrl_busy}, 32'd0);
        prev_result = exp;
    endtask

    // Cycle after DONE with no new start: ready drops, result holds
    task automatic after_done(input string tag);
        @(posedge clock); #1;
        chk({tag, " post rdy"}, {31'd0, data_resultRDY}, 32'd0);
        chk({tag, " post busy"}, {31'd0, ctrl_busy}, 32'd0);
        chk({tag, " post hold"}, data_result, prev_result);
    endtask

    initial begin
        logic [31:0] a;
        reset         = 1'b1;
        ctrl_start    = 1'b0;
        data_operandA = 32'h0;
        ctrl_shiftamt = 5'd0;
        prev_result   = 32'h0;
        #1;
        chk("reset result", data_result, 32'h0);
        chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset busy", {31'd0, ctrl_busy}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Highest bit reached by maximum shift
        run_op("one_sh31", 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
        after_done("one_sh31");

        // Zero amount still takes full latency; partial shifts discard high bits
        run_op("dead_sh0", 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0);
        after_done("dead_sh0");
        run_op("dead_sh4", 32'hDEAD_BEEF, 5'd4, 32'hEADB_EEF0, 1'b0);
        after_done("dead_sh4");
        run_op("dead_sh16", 32'hDEAD_BEEF, 5'd16, 32'hBEEF_0000, 1'b0);
        after_done("dead_sh16");

        // Start pulse and input changes while shifting are ignored
        run_op("ffff_sh8", 32'h0000_FFFF, 5'd8, 32'h00FF_FF00, 1'b1);
        after_done("ffff_sh8");
        @(posedge clock); #1;
        chk("ffff_sh8 idle rdy", {31'd0, data_resultRDY}, 32'd0);

        // Back-to-back: start held in the DONE cycle
        run_op("b2b_first", 32'h0000_0010, 5'd2, 32'h0000_0040, 1'b0);
        ctrl_start    = 1'b1;
        data_operandA = 32'h0000_0003;
        ctrl_shiftamt = 5'd1;
        @(posedge clock); #1;
        chk("b2b accept busy", {31'd0, ctrl_busy}, 32'd1);
        chk("b2b accept rdy", {31'd0, data_resultRDY}, 32'd0);
        ctrl_start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock); #1;
            chk("b2b shift rdy", {31'd0, data_resultRDY}, 32'd0);
            chk("b2b shift hold", data_result, 32'h0000_0040);
        end
        @(posedge clock); #1;
        chk("b2b second rdy", {31'd0, data_resultRDY}, 32'd1);
        chk("b2b second result", data_result, 32'h0000_0006);
        prev_result = 32'h0000_0006;
        after_done("b2b_second");

        // Reset asserted just after E3 aborts the shift immediately
        @(negedge clock);
        ctrl_start    = 1'b1;
        data_operandA = 32'h1234_5678;
        ctrl_shiftamt = 5'd3;
        @(posedge clock);
        @(negedge clock);
        ctrl_start = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("abort result", data_result, 32'h0);
        chk("abort busy", {31'd0, ctrl_busy}, 32'd0);
        chk("abort rdy", {31'd0, data_resultRDY}, 32'd0);
        repeat (4) begin
            @(posedge clock); #1;
            chk("abort no rdy", {31'd0, data_resultRDY}, 32'd0);
        end
        @(negedge clock);
        reset       = 1'b0;
        prev_result = 32'h0;
        @(posedge clock); #1;
        chk("abort idle rdy", {31'd0, data_resultRDY}, 32'd0);
        run_op("post_reset", 32'h1234_5678, 5'd3, 32'h91A2_B3C0, 1'b0);
        after_done("post_reset");

        // Sweep every shift amount with a random operand
        for (int s = 0; s < 32; s++) begin
            a = $urandom;
            run_op($sformatf("sweep_%0d", s), a, s[4:0], a << s, 1'b0);
            after_done($sformatf("sweep_%0d", s));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
